fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and program-counter stage of the 8-bit CPU, directly upstream of `control_unit`. It owns the PC and instruction register and reads each 16-bit instruction as two bytes from byte-wide instruction memory. It presents the decoded fields (`opcode` feeds `control_unit`) and updates the PC from the `pc_inc_en`, `pc_load_en` and `halt` outputs that `control_unit` returns.

## Interface
- `RESET_PC`, default 8'h00: PC value after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  8  byte address; stable while `imem_req`=1 and `imem_valid`=0.
- `imem_rdata`  in  8  read data; valid when `imem_valid`=1.
- `imem_valid`  in  1  read response; may be asserted in the same cycle as the request (zero wait) or any later cycle.
- `instr_valid`  out  1  high while an instruction is presented to control/execute.
- `opcode`  out  4  IR[15:12].
- `rd`  out  2  IR[11:10].
- `rs`  out  2  IR[9:8].
- `imm`  out  8  IR[7:0]; immediate, memory address or jump target.
- `exec_done`  in  1  execute stage has finished the presented instruction.
- `pc_inc_en`, `pc_load_en`, `halt`  in  1 each  from `control_unit`.
- `pc`  out  8  current instruction address.
- `halted`  out  1  sticky halt indicator.

## Operation
- Instruction format:
  - High byte at `pc`; low byte at `pc+1`.
  - Big-endian: IR[15:8] = mem[pc], IR[7:0] = mem[pc+1].
- FSM states: FETCH_HI, FETCH_LO, EXEC, HALTED.
- FETCH_HI:
  - Outputs: `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_valid`: IR[15:8] <= `imem_rdata`; go to FETCH_LO.
- FETCH_LO:
  - Outputs: `imem_req`=1, `imem_addr`=`pc+1` (mod 256).
  - On `imem_valid`: IR[7:0] <= `imem_rdata`; go to EXEC.
- EXEC:
  - `instr_valid`=1; fields are stable; `imem_req`=0.
  - While `exec_done`=0: stay in EXEC.
  - When `exec_done`=1, the same edge acts on the `control_unit` inputs with this priority:
    - `halt`: go to HALTED; PC unchanged.
    - else `pc_load_en`: PC <= `imm`; go to FETCH_HI.
    - else `pc_inc_en`: PC <= PC+2 (mod 256); go to FETCH_HI.
    - else: PC unchanged (re-fetch the same instruction); go to FETCH_HI.
- HALTED:
  - `halted`=1, `imem_req`=0, `instr_valid`=0.
  - Only `rst` exits this state.
- `imem_valid` is ignored outside FETCH_HI/FETCH_LO.
- Outputs are decoded from the registered state and IR; no input-to-output combinational path except none.

## Timing
- Reset values:
  - State FETCH_HI, PC=`RESET_PC`, IR=16'h0000 (so `opcode`, `rd`, `rs` and `imm` are all 0).
  - `instr_valid`=0, `halted`=0.
  - `imem_req`=1 and `imem_addr`=`RESET_PC` in the first cycle after reset.
- `rst` wins over every other input. A response arriving in the reset cycle is discarded, and reset is honoured from any state, including mid-fetch and HALTED.
- Minimum throughput, with zero-wait memory and `exec_done` held at 1: 3 cycles per instruction (FETCH_HI, FETCH_LO, EXEC).
- Each wait cycle of memory adds one cycle. Each cycle `exec_done` stays low extends EXEC by one cycle.
- `instr_valid` rises the cycle after the low-byte response and falls the cycle after `exec_done`=1.
- PC changes only on the EXEC exit edge, so `pc` equals the address of the presented instruction throughout EXEC.
- Wrap-around:
  - With PC=8'hFF, the low byte is fetched from 8'h00.
  - PC+2 from 8'hFE gives 8'h00; from 8'hFF it gives 8'h01.
- Jump targets may be odd; there is no alignment check.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum.
  - Opcode constants: OP_NOP=0, OP_LDI=1, OP_LOAD=2, OP_STORE=3, OP_ADD=4 … OP_DEC=10, OP_JMP=11, OP_JZ=12, OP_JNZ=14, OP_HLT=15.
  - IR field-position localparams.
- One sub-module, `program_counter`: 8-bit register with synchronous reset to `RESET_PC`, load (priority) and +2 increment. FSM and IR stay in `fetch_unit`.

## Test plan
- Straight-line fetch:
  - Stimulus: reset; mem[00]=8'h4D, mem[01]=8'h12; zero-wait memory; `exec_done`=1; `pc_inc_en`=1.
  - Response: in EXEC, `opcode`=4, `rd`=3, `rs`=1, `imm`=8'h12, `pc`=00. Next `imem_addr`=02, 3 cycles after the first request.
- Jump:
  - Stimulus: mem[00..01]=B0 37; `pc_load_en`=1 and `pc_inc_en`=1 together.
  - Response: load wins; next fetch address 8'h37, then 8'h38.
- Memory wait states:
  - Stimulus: `imem_valid` delayed 3 cycles on each byte.
  - Response: `imem_addr` held at 00, then 01; IR unchanged until `imem_valid`; `instr_valid` first high at cycle 8.
- Execute stall and halt:
  - Stimulus: `exec_done` low 4 cycles with `opcode`=F.
  - Response: `instr_valid` stays 1 and fields stay stable. On `exec_done` with `halt`=1: `halted`=1 and `imem_req`=0 indefinitely, PC unchanged, `imem_valid` pulses ignored.
- Wrap:
  - Stimulus: jump to 8'hFF.
  - Response: fetch addresses FF then 00; after increment, `pc`=01.
- Reset mid-fetch:
  - Stimulus: `rst` asserted in FETCH_LO together with `imem_valid`=1.
  - Response: next cycle state FETCH_HI, PC=`RESET_PC`, IR=0, `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: fetch FSM states, opcode map and
// instruction-register field positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    EXEC     = 2'd2,
    HALTED   = 2'd3
  } fetch_state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LDI   = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_INC   = 4'd9;
  localparam logic [3:0] OP_DEC   = 4'd10;
  localparam logic [3:0] OP_JMP   = 4'd11;
  localparam logic [3:0] OP_JZ    = 4'd12;
  localparam logic [3:0] OP_JNZ   = 4'd14;
  localparam logic [3:0] OP_HLT   = 4'd15;

  localparam int IR_OPCODE_MSB = 15;
  localparam int IR_OPCODE_LSB = 12;
  localparam int IR_RD_MSB     = 11;
  localparam int IR_RD_LSB     = 10;
  localparam int IR_RS_MSB     = 9;
  localparam int IR_RS_LSB     = 8;
  localparam int IR_IMM_MSB    = 7;
  localparam int IR_IMM_LSB    = 0;

  // Instructions are two bytes, so sequential flow advances by two.
  localparam logic [7:0] PC_STEP = 8'd2;

endpackage

// File: rtl/program_counter.sv
// Program counter: synchronous reset, load has priority over +2 increment.
module program_counter
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       inc,
  output logic [7:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads each 16-bit instruction big-endian as two
// bytes, presents the decoded fields and updates the PC on EXEC exit.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  input  logic       imem_valid,
  output logic       instr_valid,
  output logic [3:0] opcode,
  output logic [1:0] rd,
  output logic [1:0] rs,
  output logic [7:0] imm,
  input  logic       exec_done,
  input  logic       pc_inc_en,
  input  logic       pc_load_en,
  input  logic       halt,
  output logic [7:0] pc,
  output logic       halted
);

  fetch_state_t state, state_next;
  logic [15:0]  ir;
  logic         exec_exit;
  logic         pc_load;
  logic         pc_inc;

  // Halt suppresses any PC update on the EXEC exit edge.
  assign exec_exit = (state == EXEC) && exec_done;
  assign pc_load   = exec_exit && !halt && pc_load_en;
  assign pc_inc    = exec_exit && !halt && pc_inc_en;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .load_value (ir[IR_IMM_MSB:IR_IMM_LSB]),
    .inc        (pc_inc),
    .pc         (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_HI;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    unique case (state)
      FETCH_HI: if (imem_valid) state_next = FETCH_LO;
      FETCH_LO: if (imem_valid) state_next = EXEC;
      EXEC:     if (exec_done)  state_next = halt ? HALTED : FETCH_HI;
      HALTED:   state_next = HALTED;
      default:  state_next = FETCH_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir <= 16'h0000;
    end else if (state == FETCH_HI && imem_valid) begin
      ir[15:8] <= imem_rdata;
    end else if (state == FETCH_LO && imem_valid) begin
      ir[7:0] <= imem_rdata;
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state)
      FETCH_HI: imem_req = 1'b1;
      FETCH_LO: begin
        imem_req  = 1'b1;
        imem_addr = pc + 8'd1;
      end
      EXEC:     instr_valid = 1'b1;
      HALTED:   halted = 1'b1;
      default:  imem_req = 1'b0;
    endcase
  end

  assign opcode = ir[IR_OPCODE_MSB:IR_OPCODE_LSB];
  assign rd     = ir[IR_RD_MSB:IR_RD_LSB];
  assign rs     = ir[IR_RS_MSB:IR_RS_LSB];
  assign imm    = ir[IR_IMM_MSB:IR_IMM_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a byte-count reference model.
module tb_fetch_unit;

  localparam logic [7:0] RESET_PC = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata = 8'h00;
  logic       imem_valid = 1'b0;
  logic       instr_valid;
  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] imm;
  logic       exec_done = 1'b0;
  logic       pc_inc_en = 1'b0;
  logic       pc_load_en = 1'b0;
  logic       halt = 1'b0;
  logic [7:0] pc;
  logic       halted;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .imm         (imm),
    .exec_done   (exec_done),
    .pc_inc_en   (pc_inc_en),
    .pc_load_en  (pc_load_en),
    .halt        (halt),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Instruction memory and responder.
  logic [7:0] mem [256];
  int         wait_n = 0;
  bit         random_mode = 1'b0;
  int         resp_cnt = 0;
  logic       rst_seen;

  always @(posedge clk) begin
    logic v;
    rst_seen = rst;
    #1;
    if (rst_seen) resp_cnt = 0;
    if (imem_req) begin
      v = random_mode ? ($urandom % 3 != 0) : (resp_cnt >= wait_n);
      resp_cnt = v ? 0 : resp_cnt + 1;
    end else begin
      v = 1'($urandom);
      resp_cnt = 0;
    end
    imem_valid = v;
    imem_rdata = (v && imem_req) ? mem[imem_addr] : 8'($urandom);
  end

  // Reference model: PC, bytes of the current instruction received so far,
  // the instruction taken straight from memory, and a sticky halt.
  logic [7:0]  m_pc;
  int          m_got;
  logic [15:0] m_ir;
  bit          m_halted;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    logic [7:0] a;
    if (rst) begin
      m_pc = RESET_PC; m_got = 0; m_ir = 16'h0000; m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_got < 2) begin
        if (imem_valid) begin
          a = m_pc + 8'(m_got);
          if (m_got == 0) m_ir[15:8] = mem[a];
          else            m_ir[7:0]  = mem[a];
          m_got++;
        end
      end else if (exec_done) begin
        if (halt) m_halted = 1'b1;
        else begin
          if (pc_load_en)     m_pc = m_ir[7:0];
          else if (pc_inc_en) m_pc = m_pc + 8'd2;
          m_got = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_req", 16'(imem_req), 16'(!m_halted && m_got < 2));
      if (!m_halted && m_got < 2) check("m_addr", 16'(imem_addr), 16'(8'(m_pc + 8'(m_got))));
      check("m_instr_valid", 16'(instr_valid), 16'(!m_halted && m_got == 2));
      check("m_halted", 16'(halted), 16'(m_halted));
      check("m_pc", 16'(pc), 16'(m_pc));
      if (!m_halted && m_got == 2) check("m_fields", {opcode, rd, rs, imm}, m_ir);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Straight-line fetch.
    mem[0] = 8'h4D; mem[1] = 8'h12;
    exec_done = 1'b1; pc_inc_en = 1'b1;
    do_reset();
    check("rst_req", 16'(imem_req), 16'h1);
    check("rst_addr", 16'(imem_addr), 16'h00);
    check("rst_instr_valid", 16'(instr_valid), 16'h0);
    check("rst_halted", 16'(halted), 16'h0);
    check("rst_fields", {opcode, rd, rs, imm}, 16'h0000);
    check("rst_pc", 16'(pc), 16'h00);
    cyc();
    check("lo_addr", 16'(imem_addr), 16'h01);
    cyc();
    check("exec_valid", 16'(instr_valid), 16'h1);
    check("exec_opcode", 16'(opcode), 16'h4);
    check("exec_rd", 16'(rd), 16'h3);
    check("exec_rs", 16'(rs), 16'h1);
    check("exec_imm", 16'(imm), 16'h12);
    check("exec_pc", 16'(pc), 16'h00);
    cyc();
    check("next_addr", 16'(imem_addr), 16'h02);

    // Jump: load wins over increment.
    mem[0] = 8'hB0; mem[1] = 8'h37; mem[8'h37] = 8'h10; mem[8'h38] = 8'h20;
    pc_load_en = 1'b1;
    do_reset();
    cyc(); cyc();
    check("jmp_opcode", 16'(opcode), 16'hB);
    cyc();
    check("jmp_addr_hi", 16'(imem_addr), 16'h37);
    cyc();
    check("jmp_addr_lo", 16'(imem_addr), 16'h38);

    // Memory wait states: three idle cycles before each byte.
    mem[0] = 8'h5A; mem[1] = 8'hC3;
    pc_load_en = 1'b0; exec_done = 1'b0; wait_n = 3;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) check("wait_addr", 16'(imem_addr), (c < 4) ? 16'h00 : 16'h01);
      check("wait_instr_valid", 16'(instr_valid), 16'(c == 8));
      check("wait_opcode", 16'(opcode), (c < 4) ? 16'h0 : 16'h5);
      check("wait_imm", 16'(imm), (c < 8) ? 16'h00 : 16'hC3);
      if (c < 8) cyc();
    end

    // Execute stall then halt.
    wait_n = 0; mem[0] = 8'hF0; mem[1] = 8'hAB;
    do_reset();
    cyc(); cyc();
    for (int k = 0; k < 4; k++) begin
      check("stall_valid", 16'(instr_valid), 16'h1);
      check("stall_fields", {opcode, rd, rs, imm}, 16'hF0AB);
      cyc();
    end
    exec_done = 1'b1; halt = 1'b1;
    cyc();
    for (int k = 0; k < 6; k++) begin
      check("halt_halted", 16'(halted), 16'h1);
      check("halt_req", 16'(imem_req), 16'h0);
      check("halt_pc", 16'(pc), 16'h00);
      cyc();
    end

    // Wrap-around at the top of the address space.
    halt = 1'b0; mem[0] = 8'hB0; mem[1] = 8'hFF; mem[8'hFF] = 8'h41;
    pc_load_en = 1'b1; pc_inc_en = 1'b0;
    do_reset();
    cyc(); cyc(); cyc();
    check("wrap_addr_hi", 16'(imem_addr), 16'hFF);
    pc_load_en = 1'b0; pc_inc_en = 1'b1;
    cyc();
    check("wrap_addr_lo", 16'(imem_addr), 16'h00);
    cyc();
    check("wrap_exec_pc", 16'(pc), 16'hFF);
    check("wrap_fields", {opcode, rd, rs, imm}, 16'h41B0);
    cyc();
    check("wrap_pc_inc", 16'(pc), 16'h01);

    // Reset in FETCH_LO with a response in the same cycle.
    mem[0] = 8'h9C; mem[1] = 8'h77; exec_done = 1'b0;
    do_reset();
    cyc();
    check("midrst_lo_addr", 16'(imem_addr), 16'h01);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_addr", 16'(imem_addr), 16'(RESET_PC));
    check("midrst_pc", 16'(pc), 16'(RESET_PC));
    check("midrst_fields", {opcode, rd, rs, imm}, 16'h0000);
    check("midrst_instr_valid", 16'(instr_valid), 16'h0);
    cyc();
    check("midrst_refetch_addr", 16'(imem_addr), 16'h01);
    check("midrst_refetch_opcode", 16'(opcode), 16'h9);

    // Randomized traffic against the model.
    random_mode = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom % 64 == 0);
      exec_done  = 1'($urandom);
      halt       = ($urandom % 16 == 0);
      pc_load_en = ($urandom % 4 == 0);
      pc_inc_en  = ($urandom % 4 != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
